// File: rtl/adc_serial_seq_pkg.sv
// rtl/adc_serial_seq_pkg.sv - shared state encoding and sizing helpers for the digit-serial adder sequencer
package adc_serial_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int seq_steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int step_cnt_w(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/adc_serial_seq_if.sv
// rtl/adc_serial_seq_if.sv - requester/consumer handshake bundle; ADC_SERIAL_SEQ_SUB_EN adds the SUB select
interface adc_serial_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             CIN;
`ifdef ADC_SERIAL_SEQ_SUB_EN
    logic             SUB;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] O;
    logic             COUT;
    logic             busy;

    modport master (
`ifdef ADC_SERIAL_SEQ_SUB_EN
        output SUB,
`endif
        output in_valid, I0, I1, CIN, out_ready,
        input  in_ready, out_valid, O, COUT, busy
    );

    modport slave (
`ifdef ADC_SERIAL_SEQ_SUB_EN
        input  SUB,
`endif
        input  in_valid, I0, I1, CIN, out_ready,
        output in_ready, out_valid, O, COUT, busy
    );
endinterface

// File: rtl/adc_digit.sv
// rtl/adc_digit.sv - combinational DIGIT-bit add-with-carry slice
module adc_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] I0,
    input  logic [DIGIT-1:0] I1,
    input  logic             CIN,
    output logic [DIGIT-1:0] O,
    output logic             COUT
);

    assign {COUT, O} = {1'b0, I0} + {1'b0, I1} + {{DIGIT{1'b0}}, CIN};

endmodule

// File: rtl/adc_serial_seq.sv
// rtl/adc_serial_seq.sv - digit-serial WIDTH-bit adder sequencer, LSB digit first
// ADC_SERIAL_SEQ_SUB_EN adds subtract via inverted operand B and inverted carry-in.
module adc_serial_seq
    import adc_serial_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic CLK,
    input  logic ASYNCRESET,
    adc_serial_seq_if.slave bus
);

    localparam int STEPS = seq_steps(WIDTH, DIGIT);
    localparam int CNT_W = step_cnt_w(STEPS);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_o;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_step;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic [WIDTH-1:0] w_res_next;

    adc_digit #(.DIGIT(DIGIT)) u_digit (
        .I0   (r_a[DIGIT-1:0]),
        .I1   (r_b[DIGIT-1:0]),
        .CIN  (r_carry),
        .O    (w_sum),
        .COUT (w_cout)
    );

`ifdef ADC_SERIAL_SEQ_SUB_EN
    assign w_b_in = bus.SUB ? ~bus.I1  : bus.I1;
    assign w_c_in = bus.SUB ? ~bus.CIN : bus.CIN;
`else
    assign w_b_in = bus.I1;
    assign w_c_in = bus.CIN;
`endif

    assign w_last     = (r_step == CNT_W'(STEPS - 1));
    // New digit lands at the MSB end so the full result is aligned after STEPS shifts.
    assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_o     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_step  <= '0;
        end else if (w_accept) begin
            r_a     <= bus.I0;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_step  <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_res   <= w_res_next;
            r_carry <= w_cout;
            r_step  <= r_step + CNT_W'(1);
            // O/COUT only change on the final digit so they hold the previous result during RUN.
            if (w_last) begin
                r_o    <= w_res_next;
                r_cout <= w_cout;
            end
        end
    end

    assign bus.O    = r_o;
    assign bus.COUT = r_cout;

endmodule

// File: tb/tb_adc_serial_seq.sv
// tb/tb_adc_serial_seq.sv - bench for adc_serial_seq with DIGIT=1 and DIGIT=4 instances in lockstep
module tb_adc_serial_seq;

    logic       CLK;
    logic       ASYNCRESET;
    logic       tv_valid;
    logic       tv_ready;
    logic [7:0] tv_a;
    logic [7:0] tv_b;
    logic       tv_cin;
`ifdef ADC_SERIAL_SEQ_SUB_EN
    logic       tv_sub;
`endif

    int n_total = 0;
    int n_pass  = 0;

    adc_serial_seq_if #(.WIDTH(8)) if1 ();
    adc_serial_seq_if #(.WIDTH(8)) if4 ();

    assign if1.in_valid  = tv_valid;
    assign if1.I0        = tv_a;
    assign if1.I1        = tv_b;
    assign if1.CIN       = tv_cin;
    assign if1.out_ready = tv_ready;
    assign if4.in_valid  = tv_valid;
    assign if4.I0        = tv_a;
    assign if4.I1        = tv_b;
    assign if4.CIN       = tv_cin;
    assign if4.out_ready = tv_ready;
`ifdef ADC_SERIAL_SEQ_SUB_EN
    assign if1.SUB = tv_sub;
    assign if4.SUB = tv_sub;
`endif

    adc_serial_seq #(.WIDTH(8), .DIGIT(1)) dut1 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(if1));
    adc_serial_seq #(.WIDTH(8), .DIGIT(4)) dut4 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(if4));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_o;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic sub, output logic [7:0] o, output logic c);
        int r;
        if (sub) begin
            r = int'(a) - int'(b) - int'(cin);
            c = (r >= 0);
            o = 8'(r + 512);
        end else begin
            r = int'(a) + int'(b) + int'(cin);
            c = (r > 255);
            o = 8'(r);
        end
    endfunction

    task automatic start_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge CLK);
        chk({name, " in_ready1"}, 32'(if1.in_ready), 32'd1);
        chk({name, " in_ready4"}, 32'(if4.in_ready), 32'd1);
        tv_valid = 1'b1;
        tv_a     = a;
        tv_b     = b;
        tv_cin   = cin;
        @(posedge CLK);
        #1;
        tv_valid = 1'b0;
        tv_a     = 8'($urandom);
        tv_b     = 8'($urandom);
        tv_cin   = 1'($urandom);
        chk({name, " busy1"}, 32'(if1.busy), 32'd1);
        chk({name, " busy4"}, 32'(if4.busy), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int lat1 = 0;
        int lat4 = 0;
        for (int c = 1; c <= 20 && (lat1 == 0 || lat4 == 0); c++) begin
            @(posedge CLK);
            #1;
            if (if1.out_valid && lat1 == 0) lat1 = c;
            if (if4.out_valid && lat4 == 0) lat4 = c;
        end
        chk({name, " latency1"}, 32'(lat1), 32'd8);
        chk({name, " latency4"}, 32'(lat4), 32'd2);
    endtask

    task automatic check_result(input string name, input logic [7:0] eo, input logic ec);
        chk({name, " O1"}, 32'(if1.O), 32'(eo));
        chk({name, " COUT1"}, 32'(if1.COUT), 32'(ec));
        chk({name, " O4"}, 32'(if4.O), 32'(eo));
        chk({name, " COUT4"}, 32'(if4.COUT), 32'(ec));
    endtask

    task automatic release_out(input string name);
        @(negedge CLK);
        tv_ready = 1'b1;
        @(posedge CLK);
        #1;
        tv_ready = 1'b0;
        chk({name, " out_valid1 drop"}, 32'(if1.out_valid), 32'd0);
        chk({name, " out_valid4 drop"}, 32'(if4.out_valid), 32'd0);
        chk({name, " in_ready1 back"}, 32'(if1.in_ready), 32'd1);
        chk({name, " in_ready4 back"}, 32'(if4.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb, eo;
        logic       rc, rs, ec, seen;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'hAB, 8'h67, 1'b1, 8'h13, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};

        ASYNCRESET = 1'b0;
        tv_valid   = 1'b0;
        tv_ready   = 1'b0;
        tv_a       = 8'h00;
        tv_b       = 8'h00;
        tv_cin     = 1'b0;
`ifdef ADC_SERIAL_SEQ_SUB_EN
        tv_sub     = 1'b0;
`endif

        #2 ASYNCRESET = 1'b1;
        #1;
        chk("reset async in_ready", 32'(if1.in_ready), 32'd1);
        chk("reset async out_valid", 32'(if1.out_valid), 32'd0);
        chk("reset async O", 32'(if1.O), 32'd0);
        chk("reset async busy4", 32'(if4.busy), 32'd0);
        repeat (2) @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        chk("reset in_ready1", 32'(if1.in_ready), 32'd1);
        chk("reset out_valid1", 32'(if1.out_valid), 32'd0);
        chk("reset O1", 32'(if1.O), 32'd0);
        chk("reset COUT1", 32'(if1.COUT), 32'd0);
        chk("reset O4", 32'(if4.O), 32'd0);
        chk("reset busy1", 32'(if1.busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_op(nm, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(nm);
            check_result(nm, vecs[i].exp_o, vecs[i].exp_cout);
            release_out(nm);
        end

        for (int i = 0; i < 16; i++) begin
            string nm;
            nm = $sformatf("rand%0d", i);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'b0;
`ifdef ADC_SERIAL_SEQ_SUB_EN
            rs     = 1'($urandom);
            tv_sub = rs;
`endif
            model(ra, rb, rc, rs, eo, ec);
            start_op(nm, ra, rb, rc);
            wait_done(nm);
            check_result(nm, eo, ec);
            release_out(nm);
        end
`ifdef ADC_SERIAL_SEQ_SUB_EN
        tv_sub = 1'b1;
        start_op("sub", 8'h10, 8'h01, 1'b0);
        wait_done("sub");
        check_result("sub", 8'h0F, 1'b1);
        release_out("sub");
        tv_sub = 1'b0;
`endif

        start_op("bp", 8'h5A, 8'h3C, 1'b1);
        wait_done("bp");
        check_result("bp", 8'h97, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            tv_valid = ~tv_valid;
            tv_a     = 8'($urandom);
            tv_b     = 8'($urandom);
            tv_cin   = 1'($urandom);
            @(posedge CLK);
            #1;
            check_result($sformatf("bp hold%0d", k), 8'h97, 1'b0);
            chk($sformatf("bp hold%0d in_ready1", k), 32'(if1.in_ready), 32'd0);
            chk($sformatf("bp hold%0d out_valid1", k), 32'(if1.out_valid), 32'd1);
            chk($sformatf("bp hold%0d out_valid4", k), 32'(if4.out_valid), 32'd1);
        end
        @(negedge CLK);
        tv_valid = 1'b1;
        tv_ready = 1'b1;
        @(posedge CLK);
        #1;
        tv_valid = 1'b0;
        tv_ready = 1'b0;
        chk("bp exit out_valid1", 32'(if1.out_valid), 32'd0);
        chk("bp exit in_ready1", 32'(if1.in_ready), 32'd1);
        chk("bp exit in_ready4", 32'(if4.in_ready), 32'd1);
        chk("bp exit busy1", 32'(if1.busy), 32'd0);

        start_op("midrst", 8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge CLK);
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("midrst in_ready1", 32'(if1.in_ready), 32'd1);
        chk("midrst busy1", 32'(if1.busy), 32'd0);
        chk("midrst out_valid4", 32'(if4.out_valid), 32'd0);
        chk("midrst O1", 32'(if1.O), 32'd0);
        chk("midrst COUT4", 32'(if4.COUT), 32'd0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            if (if1.out_valid || if4.out_valid) seen = 1'b1;
        end
        chk("midrst no out_valid", 32'(seen), 32'd0);
        start_op("post", 8'h01, 8'h01, 1'b0);
        wait_done("post");
        check_result("post", 8'h02, 1'b0);
        release_out("post");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
